adsb_rx_ctrl: RTL and testbench
===============================

# adsb_rx_ctrl

Sequencing controller for the ADS-B receive datapath. It sits between the host register bank and the `adsb_rx` / `fifo_buffer` / FIFO chain in `adsb_top`. It generates the decimation enable `dec_ena` and gates the detector enable `det_ena` against FIFO occupancy, so a message already in progress is never cut off. It also runs a per-message watchdog that pulses `watchdog_reset` to recover `fifo_buffer`, and counts lost messages for host readback.

## Interface
Parameters:
- `DIV`, 1: `dec_ena` period in clocks, legal range 1..255; DIV=1 holds `dec_ena` high.
- `HIWAT`, 8'd200: FIFO read count at or above which detection is throttled.
- `LOWAT`, 8'd128: FIFO read count at or below which throttling is released; must be < HIWAT.
- `WD_TIMEOUT`, 16'd3000: `dec_ena` ticks allowed from `data_start` to `done`.
- `WD_LEN`, 4: clocks that `watchdog_reset` is held high; legal range 1..15.

Ports:
- `clk` in 1: 20 MHz system clock.
- `reset` in 1: asynchronous, active-high reset.
- `det_ena_req` in 1: host detector-enable register bit.
- `clr` in 1: single-cycle pulse; clears `drop_cnt` and `overflow`.
- `data_start` in 1: pulse from `adsb_rx`; a message has begun.
- `done` in 1: pulse from `adsb_rx`; the message has ended.
- `fifo_count` in 8: FIFO `rd_data_count`.
- `fifo_full` in 1: FIFO full flag.
- `dec_ena` out 1: decimation enable to the datapath and stats.
- `det_ena` out 1: gated detector enable to `adsb_rx`.
- `watchdog_reset` out 1: reset pulse to `fifo_buffer`.
- `overflow` out 1: sticky flag; a message was lost.
- `drop_cnt` out 16: saturating count of lost messages.
- `state` out 3: FSM state for debug readback.

## Operation
- **Divider:** an 8-bit counter runs from 0 to DIV-1 and wraps. `dec_ena`=1 on the cycle the counter is 0. It runs in every FSM state.
- **FSM updates** are evaluated only on `dec_ena` cycles. `clr`, `drop_cnt` and `overflow` update on every clock.
- **State encodings:** IDLE=0, ARMED=1, BUSY=2, THROTTLE=3, WDOG=4.
- **Output decode:** `det_ena` = (state==ARMED or state==BUSY), decoded directly from the state register. `watchdog_reset` = (state==WDOG).
- **IDLE:**
  - If `det_ena_req`=1 and `fifo_count`<HIWAT and `fifo_full`=0 -> ARMED.
  - Else if `det_ena_req`=1 -> THROTTLE.
- **ARMED** (conditions evaluated in this priority order):
  1. `det_ena_req`=0 -> IDLE.
  2. `data_start` -> BUSY; timer cleared to 0.
  3. `fifo_count`>=HIWAT or `fifo_full` -> THROTTLE.
- **BUSY:**
  - The timer increments on each `dec_ena` tick.
  - `done` -> ARMED.
  - Otherwise, timer==WD_TIMEOUT-1 -> WDOG.
  - `det_ena_req`=0 and FIFO level are ignored in BUSY; the message is always allowed to finish.
- **THROTTLE:**
  - `det_ena_req`=0 -> IDLE.
  - Else if `fifo_count`<=LOWAT and `fifo_full`=0 -> ARMED.
- **WDOG:**
  - Evaluated on every clock, not gated by `dec_ena`.
  - A 4-bit counter holds the state for WD_LEN clocks, then -> IDLE.
- **Drop accounting:** `drop_cnt` increments by 1 and `overflow` sets on either of:
  - `done`=1 while `fifo_full`=1 (the write is lost);
  - entry into WDOG.
  - If both occur in the same cycle, `drop_cnt` increments by 1 only.
  - `drop_cnt` saturates at 16'hFFFF.
- **`clr` priority:** `clr` wins over a coincident increment; the result is `drop_cnt`=0 and `overflow`=0.
- **`done` in any state other than BUSY:** ignored by the FSM, but still counted if `fifo_full`=1.
- **`data_start` in BUSY:** ignored; the timer is not restarted.

## Timing
- **Reset values:**
  - state=IDLE; `det_ena`=0, `watchdog_reset`=0.
  - `dec_ena`=0; divider counter=0, with the first `dec_ena`=1 on the first clock after reset release.
  - `drop_cnt`=0, `overflow`=0; timer=0.
- **Reset during BUSY or WDOG:** the block returns to IDLE immediately and `watchdog_reset` drops at once; there is no residual pulse.
- **Input-to-output latency:** 1 clock. An input sampled on a `dec_ena` edge changes state on that edge, and `det_ena` reflects the new state in the following cycle.
- **Watchdog timing (DIV=1):** `watchdog_reset` rises WD_TIMEOUT clocks after the `data_start` edge and stays high for exactly WD_LEN clocks.
- **Drop counter update:** `drop_cnt` and `overflow` update 1 clock after the qualifying event.
- **Hysteresis:** with HIWAT/LOWAT defaults, `fifo_count` oscillating between 129 and 199 causes no THROTTLE exit once throttled.

## Test plan
- **Enable and throttle:** DIV=1, `det_ena_req`=1, `fifo_count`=0 -> `det_ena`=1 on the 2nd clock. Raise `fifo_count` to 200 -> `det_ena`=0 and state=3 the next clock. Lower to 129 -> still 0. Lower to 128 -> `det_ena`=1.
- **Message completes despite disable:** `data_start`, then drop `det_ena_req` 10 clocks later -> `det_ena` stays 1 until `done`. Then ARMED for 1 clock, then IDLE with `det_ena`=0.
- **Watchdog recovery:** `data_start` with no `done`, WD_TIMEOUT=3000 -> `watchdog_reset` high for clocks 3000..3003 after `data_start`. Then IDLE, `drop_cnt`=1, `overflow`=1.
- **Drop saturation and clear:**
  - Hold `fifo_full`=1 and issue 65537 `done` pulses -> `drop_cnt`=16'hFFFF.
  - `clr` coincident with another `done` -> `drop_cnt`=0, `overflow`=0.
- **Divider:** DIV=4 -> `dec_ena` pattern 1,0,0,0 repeating. A `data_start` pulse landing on a `dec_ena`=0 cycle is not seen; the state stays ARMED.
- **Asynchronous reset mid-WDOG:** assert `reset` asynchronously on WDOG cycle 2 -> `watchdog_reset`=0 and state=0 with no clock edge. `drop_cnt` is cleared.

Source files
------------

// File: rtl/adsb_rx_ctrl.sv
// adsb_rx_ctrl: sequencing controller for the ADS-B receive path.
// It generates the decimation strobe and gates the detector enable
// against FIFO occupancy. It also runs a per-message watchdog and
// counts lost messages.
module adsb_rx_ctrl #(
  parameter int unsigned DIV        = 1,
  parameter logic [7:0]  HIWAT      = 8'd200,
  parameter logic [7:0]  LOWAT      = 8'd128,
  parameter logic [15:0] WD_TIMEOUT = 16'd3000,
  parameter int unsigned WD_LEN     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        det_ena_req,
  input  logic        clr,
  input  logic        data_start,
  input  logic        done,
  input  logic [7:0]  fifo_count,
  input  logic        fifo_full,
  output logic        dec_ena,
  output logic        det_ena,
  output logic        watchdog_reset,
  output logic        overflow,
  output logic [15:0] drop_cnt,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARMED    = 3'd1,
    S_BUSY     = 3'd2,
    S_THROTTLE = 3'd3,
    S_WDOG     = 3'd4
  } state_t;

  localparam logic [7:0]  DIV_LAST = 8'(DIV - 1);
  localparam logic [3:0]  WD_LAST  = 4'(WD_LEN - 1);
  localparam logic [15:0] TO_LAST  = WD_TIMEOUT - 16'd1;

  logic [7:0]  div_cnt_q;
  logic        dec_q;
  state_t      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [3:0]  wd_cnt_q, wd_cnt_d;
  logic [15:0] drop_q, drop_d;
  logic        ovf_q, ovf_d;
  logic        wd_entry;
  logic        drop_evt;

  // Free-running divider; the strobe is registered so it is low in reset
  // and first goes high on the clock after reset is released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q <= 8'd0;
      dec_q     <= 1'b0;
    end else begin
      dec_q     <= (div_cnt_q == 8'd0);
      div_cnt_q <= (div_cnt_q == DIV_LAST) ? 8'd0 : div_cnt_q + 8'd1;
    end
  end

  // State, message timer and watchdog pulse counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      timer_q  <= 16'd0;
      wd_cnt_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      wd_cnt_q <= wd_cnt_d;
    end
  end

  // Next-state logic. Only WDOG runs every clock; the other states move on
  // decimation ticks only.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    wd_cnt_d = wd_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (dec_q && det_ena_req) begin
          if (fifo_count < HIWAT && !fifo_full) state_d = S_ARMED;
          else                                  state_d = S_THROTTLE;
        end
      end
      S_ARMED: begin
        if (dec_q) begin
          if (!det_ena_req) begin
            state_d = S_IDLE;
          end else if (data_start) begin
            state_d = S_BUSY;
            timer_d = 16'd0;
          end else if (fifo_count >= HIWAT || fifo_full) begin
            state_d = S_THROTTLE;
          end
        end
      end
      S_BUSY: begin
        // A message in flight always finishes: enable and FIFO level are ignored.
        if (dec_q) begin
          timer_d = timer_q + 16'd1;
          if (done) begin
            state_d = S_ARMED;
          end else if (timer_q == TO_LAST) begin
            state_d  = S_WDOG;
            wd_cnt_d = 4'd0;
          end
        end
      end
      S_THROTTLE: begin
        if (dec_q) begin
          if (!det_ena_req)                               state_d = S_IDLE;
          else if (fifo_count <= LOWAT && !fifo_full)     state_d = S_ARMED;
        end
      end
      S_WDOG: begin
        if (wd_cnt_q == WD_LAST) begin
          state_d  = S_IDLE;
          wd_cnt_d = 4'd0;
        end else begin
          wd_cnt_d = wd_cnt_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign wd_entry = (state_q != S_WDOG) && (state_d == S_WDOG);
  assign drop_evt = (done && fifo_full) || wd_entry;

  // Drop accounting: one count per cycle with any loss, saturating, clr wins.
  always_comb begin
    drop_d = drop_q;
    ovf_d  = ovf_q;
    if (clr) begin
      drop_d = 16'd0;
      ovf_d  = 1'b0;
    end else if (drop_evt) begin
      if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
      ovf_d = 1'b1;
    end
  end

  // Drop counter and sticky overflow registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_q <= 16'd0;
      ovf_q  <= 1'b0;
    end else begin
      drop_q <= drop_d;
      ovf_q  <= ovf_d;
    end
  end

  assign dec_ena        = dec_q;
  assign det_ena        = (state_q == S_ARMED) || (state_q == S_BUSY);
  assign watchdog_reset = (state_q == S_WDOG);
  assign overflow       = ovf_q;
  assign drop_cnt       = drop_q;
  assign state          = state_q;

endmodule

// File: tb/tb_adsb_rx_ctrl.sv
// Testbench for adsb_rx_ctrl: vector table plus multi-cycle sequences.
module tb_adsb_rx_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0, clr = 1'b0, ds = 1'b0, dn = 1'b0, full = 1'b0;
  logic [7:0]  fc = 8'd0;
  logic        dec, det, wd, ovf;
  logic [15:0] drop;
  logic [2:0]  st;
  logic        dec4, det4, wd4, ovf4;
  logic [15:0] drop4;
  logic [2:0]  st4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adsb_rx_ctrl u_dut (
    .clk(clk), .reset(reset), .det_ena_req(req), .clr(clr),
    .data_start(ds), .done(dn), .fifo_count(fc), .fifo_full(full),
    .dec_ena(dec), .det_ena(det), .watchdog_reset(wd), .overflow(ovf),
    .drop_cnt(drop), .state(st)
  );

  adsb_rx_ctrl #(.DIV(4)) u_div4 (
    .clk(clk), .reset(reset), .det_ena_req(req), .clr(clr),
    .data_start(ds), .done(dn), .fifo_count(fc), .fifo_full(full),
    .dec_ena(dec4), .det_ena(det4), .watchdog_reset(wd4), .overflow(ovf4),
    .drop_cnt(drop4), .state(st4)
  );

  typedef struct {
    logic       req, ds, dn, full, clr;
    logic [7:0] fc;
    logic       exp_det;
    logic [2:0] exp_st;
    logic [15:0] exp_drop;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  function automatic vec_t mk(input logic r, input logic s, input logic d, input logic f,
                              input logic c, input logic [7:0] cnt, input logic edet,
                              input logic [2:0] est, input logic [15:0] edrop, input logic eovf);
    vec_t v;
    v.req = r; v.ds = s; v.dn = d; v.full = f; v.clr = c; v.fc = cnt;
    v.exp_det = edet; v.exp_st = est; v.exp_drop = edrop; v.exp_ovf = eovf;
    return v;
  endfunction

  initial begin
    int  early;
    bit  found;
    logic [3:0] dpat;

    //            req ds dn full clr fc     det st drop ovf
    vecs[0]  = mk(1, 0, 0, 0, 0, 8'd0,   0, 0, 0, 0);
    vecs[1]  = mk(1, 0, 0, 0, 0, 8'd0,   1, 1, 0, 0);
    vecs[2]  = mk(1, 0, 0, 0, 0, 8'd200, 0, 3, 0, 0);
    vecs[3]  = mk(1, 0, 0, 0, 0, 8'd129, 0, 3, 0, 0);
    vecs[4]  = mk(1, 0, 0, 0, 0, 8'd199, 0, 3, 0, 0);
    vecs[5]  = mk(1, 0, 0, 0, 0, 8'd128, 1, 1, 0, 0);
    vecs[6]  = mk(1, 1, 0, 0, 0, 8'd0,   1, 2, 0, 0);
    vecs[7]  = mk(0, 0, 0, 0, 0, 8'd0,   1, 2, 0, 0);
    vecs[8]  = mk(0, 0, 0, 0, 0, 8'd250, 1, 2, 0, 0);
    vecs[9]  = mk(0, 1, 0, 0, 0, 8'd0,   1, 2, 0, 0);
    vecs[10] = mk(0, 0, 1, 0, 0, 8'd0,   1, 1, 0, 0);
    vecs[11] = mk(0, 0, 0, 0, 0, 8'd0,   0, 0, 0, 0);
    vecs[12] = mk(1, 0, 0, 1, 0, 8'd0,   0, 3, 0, 0);
    vecs[13] = mk(1, 0, 0, 0, 0, 8'd0,   1, 1, 0, 0);
    vecs[14] = mk(1, 0, 1, 1, 0, 8'd0,   0, 3, 1, 1);
    vecs[15] = mk(1, 0, 1, 1, 1, 8'd0,   0, 3, 0, 0);
    vecs[16] = mk(0, 0, 0, 0, 0, 8'd0,   0, 0, 0, 0);

    // Reset state
    #12;
    check("rst_state", 32'(st), 32'd0);
    check("rst_det", 32'(det), 32'd0);
    check("rst_wd", 32'(wd), 32'd0);
    check("rst_dec", 32'(dec), 32'd0);
    check("rst_drop", 32'(drop), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Table of single-clock vectors
    for (int i = 0; i < 17; i++) begin
      req = vecs[i].req; ds = vecs[i].ds; dn = vecs[i].dn;
      full = vecs[i].full; clr = vecs[i].clr; fc = vecs[i].fc;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_det", i), 32'(det), 32'(vecs[i].exp_det));
      check($sformatf("v%0d_state", i), 32'(st), 32'(vecs[i].exp_st));
      check($sformatf("v%0d_drop", i), 32'(drop), 32'(vecs[i].exp_drop));
      check($sformatf("v%0d_ovf", i), 32'(ovf), 32'(vecs[i].exp_ovf));
      check($sformatf("v%0d_wd", i), 32'(wd), 32'd0);
      check($sformatf("v%0d_dec", i), 32'(dec), 32'd1);
    end
    clr = 1'b0; dn = 1'b0; ds = 1'b0; full = 1'b0; fc = 8'd0;

    // Watchdog recovery; disable and a second data_start during the message
    req = 1'b1;
    @(posedge clk); #1;
    check("wd_armed", 32'(st), 32'd1);
    ds = 1'b1;
    @(posedge clk); #1;
    ds = 1'b0;
    check("wd_busy", 32'(st), 32'd2);
    early = 0;
    for (int k = 1; k <= 3004; k++) begin
      if (k == 10) req = 1'b0;
      ds = (k == 100);
      @(posedge clk); #1;
      if (k < 3000 && wd) early++;
      if (k == 2999) begin
        check("wd_no_early", 32'(early), 32'd0);
        check("wd_busy_det", 32'(det), 32'd1);
        check("wd_busy_drop", 32'(drop), 32'd0);
      end
      if (k >= 3000 && k <= 3003) check($sformatf("wd_high_%0d", k), 32'(wd), 32'd1);
      if (k == 3000) begin
        check("wd_state", 32'(st), 32'd4);
        check("wd_drop", 32'(drop), 32'd1);
        check("wd_ovf", 32'(ovf), 32'd1);
      end
      if (k == 3004) begin
        check("wd_low_3004", 32'(wd), 32'd0);
        check("wd_idle", 32'(st), 32'd0);
        check("wd_drop_after", 32'(drop), 32'd1);
      end
    end
    ds = 1'b0;

    // Asynchronous reset on the second WDOG cycle
    do_reset();
    req = 1'b1;
    repeat (2) @(posedge clk);
    #1 ds = 1'b1;
    @(posedge clk);
    #1 ds = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 3100 && !found; i++) begin
      @(posedge clk); #1;
      if (wd) found = 1'b1;
    end
    check("ar_wd_seen", 32'(found), 32'd1);
    @(posedge clk); #1;
    check("ar_wd_cycle2", 32'(wd), 32'd1);
    check("ar_drop_pre", 32'(drop), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("ar_wd", 32'(wd), 32'd0);
    check("ar_state", 32'(st), 32'd0);
    check("ar_drop", 32'(drop), 32'd0);
    check("ar_ovf", 32'(ovf), 32'd0);

    // Divider at DIV=4 and a data_start landing off-tick
    req = 1'b1; fc = 8'd0; full = 1'b0;
    do_reset();
    dpat = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      ds = (i == 2);
      @(posedge clk); #1;
      check($sformatf("div4_dec_%0d", i), 32'(dec4), 32'(dpat[i % 4]));
      if (i == 1) check("div4_armed", 32'(st4), 32'd1);
    end
    ds = 1'b0;
    check("div4_ds_missed", 32'(st4), 32'd1);
    check("div4_det", 32'(det4), 32'd1);
    check("div4_wd", 32'(wd4), 32'd0);
    check("div4_drop", 32'(drop4), 32'd0);
    check("div4_ovf", 32'(ovf4), 32'd0);

    // Drop counter saturation, then clr against a coincident drop
    req = 1'b0;
    do_reset();
    full = 1'b1; dn = 1'b1;
    repeat (65537) @(posedge clk);
    #1;
    check("sat_drop", 32'(drop), 32'hFFFF);
    check("sat_ovf", 32'(ovf), 32'd1);
    clr = 1'b1;
    @(posedge clk); #1;
    check("clr_drop", 32'(drop), 32'd0);
    check("clr_ovf", 32'(ovf), 32'd0);
    clr = 1'b0;
    @(posedge clk); #1;
    check("clr_then_drop", 32'(drop), 32'd1);
    dn = 1'b0; full = 1'b0;
    @(posedge clk); #1;
    check("quiet_drop", 32'(drop), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
